// File: rtl/ctrl_decode_queue.sv
// ctrl_decode_queue: a small instruction queue that decodes MIPS-I control words at push time.
// It stores the decoded bundle for each entry and presents the controls of the head entry.
// A two-state FSM tracks whether the head entry sits in a branch delay slot.
// Optional build macro: DECODE_RI_EN adds a per-entry reserved-instruction flag, which drives ri.
module ctrl_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9:0]             ctrl,
  output logic [1:0]             memsz,
  output logic                   memsgn,
  output logic                   in_ds,
  output logic                   ri,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Elaboration guards on the parameter ranges
  if (IW != 32) begin : g_iw_check
    $error("ctrl_decode_queue: IW must be 32");
  end
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("ctrl_decode_queue: DEPTH must be a power of two in 2..16");
  end

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic memwrite;
    logic memtoreg;
    logic jump;
    logic al;
    logic jumpr;
    logic hilo_wr;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [1:0] memsz;
    logic       memsgn;
  } entry_t;

  typedef enum logic {NORM, SLOT} state_e;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [4:0]    rt;
  logic          unused_instr_bits;
  entry_t        dec;
  entry_t        head;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          push;
  logic          pop;
  logic          head_cti;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];
  assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

  // Decode the incoming word; any encoding not matched leaves every control at zero
  always_comb begin
    dec = '0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h08: dec.ctrl.jumpr = 1'b1;
          6'h09: begin
            dec.ctrl.regwrite = 1'b1;
            dec.ctrl.regdst   = 1'b1;
            dec.ctrl.al       = 1'b1;
            dec.ctrl.jumpr    = 1'b1;
          end
          6'h11, 6'h13: dec.ctrl.hilo_wr = 1'b1;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0C, 6'h0D,
          6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            dec.ctrl.regwrite = 1'b1;
            dec.ctrl.regdst   = 1'b1;
          end
          default: ;
        endcase
      end
      6'h01: begin
        unique case (rt)
          5'h00, 5'h01: dec.ctrl.branch = 1'b1;
          5'h10, 5'h11: begin
            dec.ctrl.regwrite = 1'b1;
            dec.ctrl.branch   = 1'b1;
            dec.ctrl.al       = 1'b1;
          end
          default: ;
        endcase
      end
      6'h02: dec.ctrl.jump = 1'b1;
      6'h03: begin
        dec.ctrl.regwrite = 1'b1;
        dec.ctrl.jump     = 1'b1;
        dec.ctrl.al       = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: dec.ctrl.branch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec.ctrl.regwrite = 1'b1;
        dec.ctrl.alusrc   = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.ctrl.regwrite = 1'b1;
        dec.ctrl.alusrc   = 1'b1;
        dec.ctrl.memtoreg = 1'b1;
        dec.memsgn        = (op == 6'h20) || (op == 6'h21);
        dec.memsz         = (op == 6'h23) ? 2'b10 :
                            ((op == 6'h21) || (op == 6'h25)) ? 2'b01 : 2'b00;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.ctrl.alusrc   = 1'b1;
        dec.ctrl.memwrite = 1'b1;
        dec.memsz         = (op == 6'h2B) ? 2'b10 : (op == 6'h29) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign in_ready  = resetn && (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_cti  = head.ctrl.branch | head.ctrl.jump | head.ctrl.jumpr;

  // Entry storage: written at push, never cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

`ifdef DECODE_RI_EN
  logic ri_mem_q [DEPTH];

  // Reserved-instruction flag per entry; every defined encoding sets at least one control
  always_ff @(posedge clk) begin
    if (push) begin
      ri_mem_q[wr_ptr_q] <= (dec.ctrl == '0);
    end
  end

  assign ri = out_valid && ri_mem_q[rd_ptr_q];
`else
  assign ri = 1'b0;
`endif

  // Pointer, occupancy and delay-slot state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= NORM;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Next-state: flush wins over push and pop; a popped control transfer leaves the next head in its slot
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = NORM;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        state_d  = head_cti ? SLOT : NORM;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  assign ctrl   = out_valid ? head.ctrl : '0;
  assign memsz  = out_valid ? head.memsz : 2'b00;
  assign memsgn = out_valid && head.memsgn;
  assign in_ds  = (state_q == SLOT) && out_valid;
  assign count  = count_q;

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Testbench for ctrl_decode_queue: directed scenarios plus random traffic against a queue-based reference.
module tb_ctrl_decode_queue;

  localparam int unsigned DEPTH = 4;
`ifdef DECODE_RI_EN
  localparam bit RI_EN = 1'b1;
`else
  localparam bit RI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  ctrl;
  logic [1:0]  memsz;
  logic        memsgn;
  logic        in_ds;
  logic        ri;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mq [$];
  bit          m_slot;

  ctrl_decode_queue #(.DEPTH(DEPTH), .IW(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl), .memsz(memsz),
    .memsgn(memsgn), .in_ds(in_ds), .ri(ri), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: {undef, memsgn, memsz[1:0], regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,al,jumpr,hilo_wr}
  function automatic logic [13:0] ref_decode(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic rw, rd, as, br, mw, mr, j, al, jr, hl, sg, undef;
    logic [1:0] sz;
    op = w[31:26]; fn = w[5:0]; rt = w[20:16];
    {rw, rd, as, br, mw, mr, j, al, jr, hl, sg, undef} = '0;
    sz = 2'b00;
    if (op == 6'h00) begin
      if (fn == 6'h08) jr = 1'b1;
      else if (fn == 6'h09) {rw, rd, al, jr} = 4'b1111;
      else if (fn inside {6'h11, 6'h13}) hl = 1'b1;
      else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0C, 6'h0D, 6'h10, 6'h12,
                          [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B}) {rw, rd} = 2'b11;
      else undef = 1'b1;
    end else if (op == 6'h01) begin
      if (rt inside {5'h00, 5'h01}) br = 1'b1;
      else if (rt inside {5'h10, 5'h11}) {rw, br, al} = 3'b111;
      else undef = 1'b1;
    end else if (op == 6'h02) j = 1'b1;
    else if (op == 6'h03) {rw, j, al} = 3'b111;
    else if (op inside {[6'h04:6'h07]}) br = 1'b1;
    else if (op inside {[6'h08:6'h0F]}) {rw, as} = 2'b11;
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      {rw, as, mr} = 3'b111;
      sz = (op == 6'h23) ? 2'b10 : (op inside {6'h21, 6'h25}) ? 2'b01 : 2'b00;
      sg = (op inside {6'h20, 6'h21});
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      {as, mw} = 2'b11;
      sz = (op == 6'h2B) ? 2'b10 : (op == 6'h29) ? 2'b01 : 2'b00;
    end else undef = 1'b1;
    return {undef, sg, sz, rw, rd, as, br, mw, mr, j, al, jr, hl};
  endfunction

  task automatic check_outputs();
    logic [13:0] d;
    bit has;
    has = (mq.size() != 0);
    d = '0;
    if (has) d = ref_decode(mq[0]);
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(resetn && (mq.size() < DEPTH) && !flush));
    check_eq("out_valid", 32'(out_valid), 32'(has));
    check_eq("ctrl", 32'(ctrl), 32'(d[9:0]));
    check_eq("memsz", 32'(memsz), 32'(d[11:10]));
    check_eq("memsgn", 32'(memsgn), 32'(d[12]));
    check_eq("in_ds", 32'(in_ds), 32'(has && m_slot));
    check_eq("ri", 32'(ri), 32'(RI_EN && d[13]));
  endtask

  // Model: in a delay slot exactly when the last consumed instruction was a control transfer
  task automatic model_update();
    logic [13:0] d;
    logic [31:0] h;
    bit do_push, do_pop;
    if (!resetn) return;
    if (flush) begin
      mq.delete();
      m_slot = 1'b0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (do_pop) begin
        h = mq.pop_front();
        d = ref_decode(h);
        m_slot = d[6] | d[3] | d[1];
      end
      if (do_push) mq.push_back(instr);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
    in_valid = iv; instr = w; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mq.delete();
    m_slot = 1'b0;
    in_valid = 1'b1; instr = 32'h8C220004; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  ops [12];
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h25, 6'h29, 6'h2B};
    w = $urandom();
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'h00;
      1: begin
        w[31:26] = 6'h01;
        if ($urandom_range(0, 1) == 1) w[19:17] = 3'b000;
      end
      2: w[31:26] = ops[$urandom_range(0, 11)];
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Push LW after reset
    do_reset();
    step(1'b1, 32'h8C220004, 1'b0, 1'b0);
    check_eq("lw_ctrl", 32'(ctrl), 32'(10'b1010010000));
    check_eq("lw_memsz", 32'(memsz), 32'd2);
    check_eq("lw_count", 32'(count), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Five pushes into a DEPTH=4 queue
    do_reset();
    step(1'b1, 32'h8C220004, 1'b0, 1'b0);
    step(1'b1, 32'h10220003, 1'b0, 1'b0);
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    step(1'b1, 32'h34420001, 1'b0, 1'b0);
    step(1'b1, 32'hAC220000, 1'b0, 1'b0);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    // Branch then ADDU: delay slot marking
    step(1'b1, 32'h10220003, 1'b0, 1'b0);
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    step(1'b1, 32'h34420001, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("ds_addu_in_ds", 32'(in_ds), 32'd1);
    check_eq("ds_addu_regdst", 32'(ctrl[8]), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("ds_after_in_ds", 32'(in_ds), 32'd0);

    // Flush while in SLOT with three entries and a same-cycle push
    step(1'b1, 32'h08000010, 1'b0, 1'b0);
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00221821, 1'b1, 1'b0);
    check_eq("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, 32'h00221821, 1'b0, 1'b1);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    check_eq("flush_norm_in_ds", 32'(in_ds), 32'd0);
    check_eq("flush_norm_valid", 32'(out_valid), 32'd1);

    // Undefined op 0x3F
    step(1'b1, 32'hFC000000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("op3f_ri", 32'(ri), 32'(RI_EN));
    check_eq("op3f_ctrl", 32'(ctrl), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with two entries queued
    step(1'b1, 32'h00221821, 1'b0, 1'b0);
    step(1'b1, 32'h8C220004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    mq.delete();
    m_slot = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #3;
    resetn = 1'b1;
    step(1'b1, 32'h8C220004, 1'b0, 1'b0);
    check_eq("first_push_count", 32'(count), 32'd1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      step(logic'($urandom_range(0, 9) < 7), rand_instr(), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
